// File: rtl/regfile_2r1w_pkg.sv
// Shared register-file definitions, also used by decode and execute.
// Build option: REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding.
package regfile_2r1w_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;
  localparam int RegNum     = 32;

  localparam logic [RegBus-1:0]     ZeroWord   = '0;
  localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;

  localparam logic RstEnable    = 1'b0;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic ReadEnable   = 1'b1;
  localparam logic ReadDisable  = 1'b0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register marking an issued writer
// that has not yet written back. Bit 0 never becomes set.
// Build option: REGFILE_BYPASS_EN (forwarding hits arrive from the parent).
module regfile_scoreboard
  import regfile_2r1w_pkg::*;
#(
  parameter int ADDR_W   = RegAddrBus,
  parameter int NUM_REGS = RegNum
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_wd,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic              hit1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  input  logic              hit2,
  output logic              busy1,
  output logic              busy2
);

  logic [NUM_REGS-1:0] sb_q;
  logic [NUM_REGS-1:0] sb_d;
  logic                set_now;

  // A flush cancels any issue that happens in the same cycle.
  assign set_now = !flush && iss_valid && (iss_wd != '0);

  // Next scoreboard: flush, then set on issue, then clear on writeback
  // unless the same register was just re-issued (the newer writer is pending).
  always_comb begin
    sb_d = sb_q;
    if (flush) begin
      sb_d = '0;
    end
    if (set_now) begin
      sb_d[iss_wd] = 1'b1;
    end
    if (we && (waddr != '0) && !(set_now && (iss_wd == waddr))) begin
      sb_d[waddr] = 1'b0;
    end
    sb_d[0] = 1'b0;
  end

  // Scoreboard register, wiped immediately by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  // Busy lookups; a forwarded operand is never reported busy.
  always_comb begin
    busy1 = rst && re1 && (raddr1 != '0) && sb_q[raddr1] && !hit1;
    busy2 = rst && re2 && (raddr2 != '0) && sb_q[raddr2] && !hit2;
  end

endmodule

// File: rtl/regfile_2r1w.sv
// General-purpose register file: two combinational read ports, one write
// port, $0 hardwired to zero, plus a pending-write scoreboard for stalls.
// Build option: REGFILE_BYPASS_EN forwards writeback data to same-cycle reads.
module regfile_2r1w
  import regfile_2r1w_pkg::*;
#(
  parameter int DATA_W   = RegBus,
  parameter int ADDR_W   = RegAddrBus,
  parameter int NUM_REGS = RegNum
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_wd,
  input  logic              flush,
  output logic              busy1,
  output logic              busy2
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              hit1;
  logic              hit2;

`ifdef REGFILE_BYPASS_EN
  assign hit1 = we && (waddr == raddr1) && (raddr1 != '0);
  assign hit2 = we && (waddr == raddr2) && (raddr2 != '0);
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif

  // Next register contents; writes to $0 are dropped so it stays zero.
  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != '0)) begin
      regs_d[waddr] = wdata;
    end
  end

  // One storage word per register, each cleared immediately by reset.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        regs_q[gi] <= '0;
      end else begin
        regs_q[gi] <= regs_d[gi];
      end
    end
  end

  // Read muxes: reset, disabled port and $0 give zero; forwarding beats storage.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (rst && re1 && (raddr1 != '0)) begin
      rdata1 = hit1 ? wdata : regs_q[raddr1];
    end
    if (rst && re2 && (raddr2 != '0)) begin
      rdata2 = hit2 ? wdata : regs_q[raddr2];
    end
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .iss_valid (iss_valid),
    .iss_wd    (iss_wd),
    .we        (we),
    .waddr     (waddr),
    .re1       (re1),
    .raddr1    (raddr1),
    .hit1      (hit1),
    .re2       (re2),
    .raddr2    (raddr2),
    .hit2      (hit2),
    .busy1     (busy1),
    .busy2     (busy2)
  );

endmodule

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench for regfile_2r1w: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a model.
// Build option: REGFILE_BYPASS_EN selects the forwarding expectations.
module tb_regfile_2r1w;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic        iss_valid;
  logic [4:0]  iss_wd;
  logic        flush;
  logic        busy1;
  logic        busy2;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: register contents and pending marks as plain arrays.
  logic [31:0] m_regs [32];
  bit          m_sb   [32];

  always #5 clk = ~clk;

  regfile_2r1w dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .re1       (re1),
    .raddr1    (raddr1),
    .rdata1    (rdata1),
    .re2       (re2),
    .raddr2    (raddr2),
    .rdata2    (rdata2),
    .iss_valid (iss_valid),
    .iss_wd    (iss_wd),
    .flush     (flush),
    .busy1     (busy1),
    .busy2     (busy2)
  );

  wire m_set = !flush && iss_valid && (iss_wd != 5'd0);

  // Model update: reset wipes everything; otherwise flush/issue/writeback.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      foreach (m_regs[i]) m_regs[i] <= 32'd0;
      foreach (m_sb[i]) m_sb[i] <= 1'b0;
    end else begin
      if (flush) foreach (m_sb[i]) m_sb[i] <= 1'b0;
      if (m_set) m_sb[iss_wd] <= 1'b1;
      if (we && waddr != 5'd0) begin
        m_regs[waddr] <= wdata;
        if (!(m_set && iss_wd == waddr)) m_sb[waddr] <= 1'b0;
      end
    end
  end

  function automatic bit fwd(logic [4:0] ra);
    return BYPASS && we && (waddr == ra);
  endfunction

  function automatic logic [31:0] exp_rd(logic re, logic [4:0] ra);
    if (rst !== 1'b1 || !re || ra == 5'd0) return 32'd0;
    if (fwd(ra)) return wdata;
    return m_regs[ra];
  endfunction

  function automatic logic [31:0] exp_busy(logic re, logic [4:0] ra);
    if (rst !== 1'b1 || !re || ra == 5'd0) return 32'd0;
    return {31'd0, m_sb[ra] && !fwd(ra)};
  endfunction

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Directed check: also prints one line per transaction.
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    cmp(name, act, exp);
    $display("check %-14s got %h expected %h", name, act, exp);
  endtask

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    cmp("rdata1", rdata1, exp_rd(re1, raddr1));
    cmp("rdata2", rdata2, exp_rd(re2, raddr2));
    cmp("busy1", {31'd0, busy1}, exp_busy(re1, raddr1));
    cmp("busy2", {31'd0, busy2}, exp_busy(re2, raddr2));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 0; waddr = 0; wdata = 0;
    re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;
    iss_valid = 0; iss_wd = 0; flush = 0;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    re1 = 1; raddr1 = 5'd5; re2 = 1; raddr2 = 5'd31;
    repeat (2) @(negedge clk);
    chk("rst_rdata1", rdata1, 32'd0);
    chk("rst_busy2", {31'd0, busy2}, 32'd0);
    tick();
    rst = 1'b1;

    // Read every address on both ports straight after reset.
    for (int a = 0; a < 32; a++) begin
      re1 = 1; raddr1 = 5'(a); re2 = 1; raddr2 = 5'(31 - a);
      @(negedge clk);
      chk("walk_rdata1", rdata1, 32'd0);
      chk("walk_busy2", {31'd0, busy2}, 32'd0);
      tick();
    end

    // Write r5, read it, then reset mid-cycle: contents vanish at once.
    idle(); we = 1; waddr = 5'd5; wdata = 32'h1234;
    tick();
    idle(); re1 = 1; raddr1 = 5'd5;
    @(negedge clk);
    chk("r5_written", rdata1, 32'h1234);
    #2 rst = 1'b0;
    #1 chk("r5_async_rst", rdata1, 32'd0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("r5_after_rst", rdata1, 32'd0);
    tick();

    // Writes to $0 are discarded.
    idle(); we = 1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
    tick();
    idle(); re1 = 1; raddr1 = 5'd0;
    @(negedge clk);
    chk("r0_zero", rdata1, 32'd0);
    tick();

    // r8 on both ports, then a disabled port.
    idle(); we = 1; waddr = 5'd8; wdata = 32'hDEAD_BEEF;
    tick();
    idle(); re1 = 1; raddr1 = 5'd8; re2 = 1; raddr2 = 5'd8;
    @(negedge clk);
    chk("r8_port1", rdata1, 32'hDEAD_BEEF);
    chk("r8_port2", rdata2, 32'hDEAD_BEEF);
    chk("model_r8", exp_rd(1'b1, 5'd8), 32'hDEAD_BEEF);
    re2 = 0;
    #1 chk("r8_re_off", rdata2, 32'd0);
    tick();

    // Same-cycle write and read of r3 (old value 1).
    idle(); we = 1; waddr = 5'd3; wdata = 32'h1;
    tick();
    idle(); we = 1; waddr = 5'd3; wdata = 32'hA5A5_A5A5; re1 = 1; raddr1 = 5'd3;
    @(negedge clk);
    chk("r3_same_cyc", rdata1, BYPASS ? 32'hA5A5_A5A5 : 32'h1);
    chk("model_r3", exp_rd(1'b1, 5'd3), BYPASS ? 32'hA5A5_A5A5 : 32'h1);
    tick();
    we = 0;
    @(negedge clk);
    chk("r3_next_cyc", rdata1, 32'hA5A5_A5A5);
    tick();

    // Issue to r7, then write it back.
    idle(); iss_valid = 1; iss_wd = 5'd7;
    tick();
    idle(); re2 = 1; raddr2 = 5'd7;
    @(negedge clk);
    chk("r7_busy", {31'd0, busy2}, 32'd1);
    tick();
    we = 1; waddr = 5'd7; wdata = 32'h77;
    @(negedge clk);
    chk("r7_wb_cycle", {31'd0, busy2}, BYPASS ? 32'd0 : 32'd1);
    tick();
    we = 0;
    @(negedge clk);
    chk("r7_after_wb", {31'd0, busy2}, 32'd0);
    tick();

    // Issue and writeback of r9 on the same edge: the set wins.
    idle(); iss_valid = 1; iss_wd = 5'd9; we = 1; waddr = 5'd9; wdata = 32'h99;
    tick();
    idle(); re1 = 1; raddr1 = 5'd9;
    @(negedge clk);
    chk("r9_set_wins", {31'd0, busy1}, 32'd1);
    chk("r9_data", rdata1, 32'h99);
    tick();
    idle(); iss_valid = 1; iss_wd = 5'd0; re1 = 1; raddr1 = 5'd0;
    tick();
    iss_valid = 0;
    @(negedge clk);
    chk("r0_never_busy", {31'd0, busy1}, 32'd0);
    tick();

    // Mark r4 and r6, then flush while issuing r10.
    idle(); iss_valid = 1; iss_wd = 5'd4;
    tick();
    iss_wd = 5'd6;
    tick();
    idle(); re1 = 1; raddr1 = 5'd4; re2 = 1; raddr2 = 5'd6;
    @(negedge clk);
    chk("r4_busy", {31'd0, busy1}, 32'd1);
    chk("r6_busy", {31'd0, busy2}, 32'd1);
    flush = 1; iss_valid = 1; iss_wd = 5'd10;
    tick();
    flush = 0; iss_valid = 0;
    @(negedge clk);
    chk("r4_flushed", {31'd0, busy1}, 32'd0);
    chk("r6_flushed", {31'd0, busy2}, 32'd0);
    raddr1 = 5'd10;
    #1 chk("r10_flushed", {31'd0, busy1}, 32'd0);
    tick();

    // Randomized traffic with occasional mid-cycle resets.
    for (int c = 0; c < 3000; c++) begin
      bit narrow;
      narrow    = ($urandom_range(0, 1) == 1);
      rst       = ($urandom_range(0, 149) != 0);
      we        = ($urandom_range(0, 2) == 0);
      waddr     = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      wdata     = $urandom;
      re1       = ($urandom_range(0, 5) != 0);
      raddr1    = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      re2       = ($urandom_range(0, 5) != 0);
      raddr2    = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      iss_valid = ($urandom_range(0, 2) == 0);
      iss_wd    = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      flush     = ($urandom_range(0, 39) == 0);
      tick();
    end

    idle();
    rst = 1'b1;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
